program_sayaci_uretici: RTL and testbench

- Generates the fetch program counter each cycle and issues it to instruction memory over a valid/ready handshake.
- Drives the predictor's ps_i with getir_ps_o. The predictor's atlanan_ps_o/ongoru_gecerli_o return combinationally in the same cycle and come in here as atlanan_ps_i/ongoru_gecerli_i.
- Takes execute-stage corrections on misprediction.
- Buffers corrections that arrive while a fetch request is still outstanding.

---
 rtl/program_sayaci_uretici.sv | 108 ++++++++++
 tb/tb_program_sayaci_uretici.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/program_sayaci_uretici.sv
// Fetch program counter generator: issues the fetch address over a valid/ready handshake,
// selects the next PC from corrections, buffered corrections, predictions or sequential step.
module program_sayaci_uretici #(
  parameter logic [31:0] BASLANGIC_ADRESI = 32'h4000_0000,
  parameter int unsigned ADIM             = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        durdur_i,
  input  logic        getir_hazir_i,
  input  logic        ongoru_gecerli_i,
  input  logic [31:0] atlanan_ps_i,
  input  logic        duzelt_gecerli_i,
  input  logic [31:0] duzelt_ps_i,
  output logic        getir_gecerli_o,
  output logic [31:0] getir_ps_o,
  output logic        getir_atlandi_o,
  output logic        getir_iptal_o
);

  typedef enum logic [1:0] {
    StSifir  = 2'd0,
    StIste   = 2'd1,
    StDurdur = 2'd2
  } durum_e;

  durum_e      durum_q, durum_d;
  logic [31:0] ps_q, ps_d;
  logic        bekleyen_q, bekleyen_d;
  logic [31:0] bekleyen_ps_q, bekleyen_ps_d;
  logic        iptal_q, iptal_d;

  logic        kabul;
  logic [31:0] sonraki_ps;
  logic        yukle;

  // Outputs are forced to their reset values while reset is held, since the
  // synchronous reset has not yet taken effect on the registers.
  assign getir_gecerli_o = ~rst_i & (durum_q == StIste);
  assign getir_ps_o      = rst_i ? BASLANGIC_ADRESI : ps_q;
  assign getir_iptal_o   = ~rst_i & iptal_q;
  assign kabul           = getir_gecerli_o & getir_hazir_i;
  assign getir_atlandi_o = kabul & ongoru_gecerli_i & ~duzelt_gecerli_i & ~bekleyen_q;

  always_comb begin
    durum_d       = durum_q;
    bekleyen_d    = bekleyen_q;
    bekleyen_ps_d = bekleyen_ps_q;
    iptal_d       = duzelt_gecerli_i;
    sonraki_ps    = ps_q;
    yukle         = 1'b0;

    unique case (durum_q)
      StIste: begin
        if (kabul) begin
          yukle      = 1'b1;
          bekleyen_d = 1'b0;
          durum_d    = durdur_i ? StDurdur : StIste;
          if (duzelt_gecerli_i) begin
            sonraki_ps = duzelt_ps_i;
          end else if (bekleyen_q) begin
            sonraki_ps = bekleyen_ps_q;
          end else if (ongoru_gecerli_i) begin
            sonraki_ps = atlanan_ps_i;
          end else begin
            sonraki_ps = ps_q + 32'(ADIM);
          end
        end else if (duzelt_gecerli_i) begin
          // Address must stay stable while valid is up; park the correction.
          bekleyen_d    = 1'b1;
          bekleyen_ps_d = {duzelt_ps_i[31:1], 1'b0};
        end
      end
      StSifir, StDurdur: begin
        durum_d = durdur_i ? StDurdur : StIste;
        if (duzelt_gecerli_i) begin
          yukle      = 1'b1;
          bekleyen_d = 1'b0;
          sonraki_ps = duzelt_ps_i;
        end else if (bekleyen_q) begin
          yukle      = 1'b1;
          bekleyen_d = 1'b0;
          sonraki_ps = bekleyen_ps_q;
        end
      end
      default: durum_d = StSifir;
    endcase

    ps_d = yukle ? {sonraki_ps[31:1], 1'b0} : ps_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q       <= StSifir;
      ps_q          <= BASLANGIC_ADRESI;
      bekleyen_q    <= 1'b0;
      bekleyen_ps_q <= '0;
      iptal_q       <= 1'b0;
    end else begin
      durum_q       <= durum_d;
      ps_q          <= ps_d;
      bekleyen_q    <= bekleyen_d;
      bekleyen_ps_q <= bekleyen_ps_d;
      iptal_q       <= iptal_d;
    end
  end

endmodule

// File: tb/tb_program_sayaci_uretici.sv
// Scoreboard bench for program_sayaci_uretici: a cycle-level reference model pushes the
// expected outputs for each driven cycle; a monitor pops and compares them mid-cycle.
module tb_program_sayaci_uretici;

  localparam logic [31:0] BASLANGIC = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        durdur_i = 1'b0;
  logic        getir_hazir_i = 1'b0;
  logic        ongoru_gecerli_i = 1'b0;
  logic [31:0] atlanan_ps_i = '0;
  logic        duzelt_gecerli_i = 1'b0;
  logic [31:0] duzelt_ps_i = '0;
  logic        getir_gecerli_o;
  logic [31:0] getir_ps_o;
  logic        getir_atlandi_o;
  logic        getir_iptal_o;

  always #5 clk = ~clk;

  program_sayaci_uretici dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .durdur_i         (durdur_i),
    .getir_hazir_i    (getir_hazir_i),
    .ongoru_gecerli_i (ongoru_gecerli_i),
    .atlanan_ps_i     (atlanan_ps_i),
    .duzelt_gecerli_i (duzelt_gecerli_i),
    .duzelt_ps_i      (duzelt_ps_i),
    .getir_gecerli_o  (getir_gecerli_o),
    .getir_ps_o       (getir_ps_o),
    .getir_atlandi_o  (getir_atlandi_o),
    .getir_iptal_o    (getir_iptal_o)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] ps;
    logic        at;
    logic        ip;
  } beklenen_t;

  beklenen_t sb_q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: "requesting" means a fetch request is on the bus.
  bit          m_requesting;
  logic [31:0] m_pc;
  bit          m_has_pending;
  logic [31:0] m_pending_pc;
  bit          m_prev_fix;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFE;
  endfunction

  task automatic cyc(input logic r, input logic d, input logic h, input logic o,
                     input logic [31:0] a, input logic f, input logic [31:0] fp);
    beklenen_t e;
    bit accepted;
    @(posedge clk);
    #1;
    rst_i = r; durdur_i = d; getir_hazir_i = h; ongoru_gecerli_i = o;
    atlanan_ps_i = a; duzelt_gecerli_i = f; duzelt_ps_i = fp;
    if (r) begin
      e = '{v: 1'b0, ps: BASLANGIC, at: 1'b0, ip: 1'b0};
      sb_q.push_back(e);
      m_requesting = 0; m_pc = BASLANGIC; m_has_pending = 0; m_pending_pc = '0; m_prev_fix = 0;
      return;
    end
    accepted = m_requesting && h;
    e.v  = m_requesting;
    e.ps = m_pc;
    e.ip = m_prev_fix;
    e.at = accepted && o && !f && !m_has_pending;
    sb_q.push_back(e);
    if (m_requesting) begin
      if (accepted) begin
        if (f) m_pc = align(fp);
        else if (m_has_pending) m_pc = m_pending_pc;
        else if (o) m_pc = align(a);
        else m_pc = m_pc + 32'd4;
        m_has_pending = 0;
        m_requesting = !d;
      end else if (f) begin
        m_has_pending = 1;
        m_pending_pc = align(fp);
      end
    end else begin
      if (f) begin
        m_pc = align(fp);
        m_has_pending = 0;
      end else if (m_has_pending) begin
        m_pc = m_pending_pc;
        m_has_pending = 0;
      end
      m_requesting = !d;
    end
    m_prev_fix = f;
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      beklenen_t e;
      e = sb_q.pop_front();
      check1("getir_gecerli_o", {31'd0, getir_gecerli_o}, {31'd0, e.v});
      check1("getir_ps_o", getir_ps_o, e.ps);
      check1("getir_atlandi_o", {31'd0, getir_atlandi_o}, {31'd0, e.at});
      check1("getir_iptal_o", {31'd0, getir_iptal_o}, {31'd0, e.ip});
    end
  end

  function automatic logic [31:0] rnd_addr();
    logic [31:0] tbl [4];
    tbl[0] = 32'hFFFF_FFFC;
    tbl[1] = 32'h4000_0003;
    tbl[2] = 32'h0000_0000;
    tbl[3] = 32'h4000_0800;
    if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    // 1: reset release and sequential fetch
    cyc(1, 0, 1, 0, '0, 0, '0);
    cyc(1, 0, 1, 0, '0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, '0, 0, '0);
    // 2: taken prediction at 0x4000_0010
    cyc(0, 0, 1, 1, 32'h4000_0100, 0, '0);
    cyc(0, 0, 1, 0, '0, 0, '0);
    // 3: correction while request stalled, predictor ignored
    cyc(0, 0, 0, 1, 32'h4000_0300, 1, 32'h4000_0800);
    cyc(0, 0, 0, 1, 32'h4000_0300, 0, '0);
    cyc(0, 1, 0, 0, '0, 0, '0);
    cyc(0, 0, 1, 1, 32'h4000_0300, 0, '0);
    cyc(0, 0, 1, 0, '0, 0, '0);
    // 4: correction and prediction on the accept cycle
    cyc(0, 0, 1, 1, 32'h4000_0700, 1, 32'h4000_0500);
    cyc(0, 0, 1, 0, '0, 0, '0);
    // 5: stall after accept, correction during stall
    cyc(0, 1, 1, 0, '0, 0, '0);
    cyc(0, 1, 1, 0, '0, 1, 32'h4000_0900);
    cyc(0, 1, 1, 0, '0, 0, '0);
    cyc(0, 1, 1, 0, '0, 0, '0);
    cyc(0, 0, 0, 0, '0, 0, '0);
    cyc(0, 1, 0, 0, '0, 0, '0);
    cyc(0, 1, 0, 0, '0, 0, '0);
    cyc(0, 0, 1, 0, '0, 0, '0);
    // 6: wraparound and bit-0 alignment, back-to-back corrections
    cyc(0, 0, 1, 0, '0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 1, 0, '0, 0, '0);
    cyc(0, 0, 1, 0, '0, 1, 32'h4000_0003);
    cyc(0, 0, 1, 0, '0, 1, 32'h4000_0011);
    cyc(0, 0, 1, 0, '0, 0, '0);
    // mid-request reset then random traffic
    cyc(0, 0, 0, 0, '0, 0, '0);
    cyc(1, 0, 0, 0, '0, 1, 32'h1234_5678);
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
          ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
          rnd_addr(),
          ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
          rnd_addr());
    end
    @(negedge clk);
    @(negedge clk);
    check1("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
